trans_delay_bank: RTL and testbench

//  N-channel clocked transition-delay gate: the cycle-accurate, synthesizable successor of the buf/bufif0 rise/fall delay

---
 rtl/trans_delay_pkg.sv | 38 +++
 rtl/trans_delay_bank_if.sv | 25 ++
 rtl/trans_delay_chan.sv | 101 ++++++++++
 rtl/trans_delay_bank.sv | 43 ++++
 tb/tb_trans_delay_bank.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/trans_delay_pkg.sv
// Shared types and delay selection for the clocked transition-delay bank.
package trans_delay_pkg;

    localparam int DW_MAX = 16;

    typedef enum logic [1:0] {
        TV_0 = 2'd0,
        TV_1 = 2'd1,
        TV_Z = 2'd2
    } tri_val_t;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_PEND = 1'b1
    } chan_state_t;

    // Delay is chosen by target only; from==to means no transition and no delay.
    function automatic logic [DW_MAX-1:0] sel_delay(
        input tri_val_t          from,
        input tri_val_t          to,
        input logic [DW_MAX-1:0] rise,
        input logic [DW_MAX-1:0] fall,
        input logic [DW_MAX-1:0] toff,
        input logic              three_d
    );
        logic [DW_MAX-1:0] res;
        res = '0;
        if (from != to) begin
            case (to)
                TV_1:    res = rise;
                TV_0:    res = fall;
                default: res = three_d ? toff : ((rise < fall) ? rise : fall);
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/trans_delay_bank_if.sv
// Bundle of per-channel stimulus, delay settings and tri-state outputs.
interface trans_delay_bank_if #(
    parameter int NCH = 4,
    parameter int DW  = 6
) ();
    logic [NCH-1:0] d;
    logic [NCH-1:0] ctl;
    logic [DW-1:0]  rise_dly;
    logic [DW-1:0]  fall_dly;
    logic [DW-1:0]  turnoff_dly;
    logic [NCH-1:0] q;
    logic [NCH-1:0] q_en;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] cancel;

    modport master (
        output d, ctl, rise_dly, fall_dly, turnoff_dly,
        input  q, q_en, busy, cancel
    );

    modport slave (
        input  d, ctl, rise_dly, fall_dly, turnoff_dly,
        output q, q_en, busy, cancel
    );
endinterface

// File: rtl/trans_delay_chan.sv
// One channel: inertial transition delay from (d, ctl) target to a 0/1/Z output.
//  state   | meaning
//  CH_IDLE | output equals target, nothing scheduled
//  CH_PEND | pend_q scheduled, commits when cnt_q reaches 0 with target unchanged
module trans_delay_chan
    import trans_delay_pkg::*;
#(
    parameter int DW      = 6,
    parameter int THREE_D = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d,
    input  logic          ctl,
    input  logic [DW-1:0] rise_dly,
    input  logic [DW-1:0] fall_dly,
    input  logic [DW-1:0] turnoff_dly,
    output logic          q,
    output logic          q_en,
    output logic          busy,
    output logic          cancel
);

    chan_state_t   state_q, state_d;
    tri_val_t      out_q, out_d;
    tri_val_t      pend_q, pend_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          cancel_q, cancel_d;

    tri_val_t      tgt;
    logic [DW-1:0] dly_new;
    logic          sched;

    always_comb begin
        tgt     = ctl ? TV_Z : (d ? TV_1 : TV_0);
        dly_new = DW'(sel_delay(out_q, tgt, DW_MAX'(rise_dly), DW_MAX'(fall_dly),
                                DW_MAX'(turnoff_dly), THREE_D != 0));
        state_d  = state_q;
        out_d    = out_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        cancel_d = 1'b0;
        sched    = 1'b0;

        case (state_q)
            CH_IDLE: begin
                if (tgt != out_q) sched = 1'b1;
            end
            CH_PEND: begin
                if (tgt == pend_q) begin
                    if (cnt_q == '0) begin
                        out_d   = pend_q;
                        state_d = CH_IDLE;
                    end else begin
                        cnt_d = cnt_q - DW'(1);
                    end
                end else if (tgt == out_q) begin
                    cancel_d = 1'b1;
                    state_d  = CH_IDLE;
                end else begin
                    sched = 1'b1;
                end
            end
            default: state_d = CH_IDLE;
        endcase

        // Fresh schedule or reschedule toward a third value, timed from this edge.
        if (sched) begin
            if (dly_new == '0) begin
                out_d   = tgt;
                state_d = CH_IDLE;
            end else begin
                state_d = CH_PEND;
                cnt_d   = dly_new - DW'(1);
                pend_d  = tgt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CH_IDLE;
            out_q    <= TV_Z;
            pend_q   <= TV_Z;
            cnt_q    <= '0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            cancel_q <= cancel_d;
        end
    end

    assign q      = (out_q == TV_1);
    assign q_en   = (out_q != TV_Z);
    assign busy   = (state_q == CH_PEND);
    assign cancel = cancel_q;

endmodule

// File: rtl/trans_delay_bank.sv
// NCH independent transition-delay channels sharing the delay settings.
module trans_delay_bank
    import trans_delay_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DW      = 6,
    parameter int THREE_D = 0
) (
    input logic               clk,
    input logic               reset,
    trans_delay_bank_if.slave bus
);

    logic [NCH-1:0] q_v;
    logic [NCH-1:0] q_en_v;
    logic [NCH-1:0] busy_v;
    logic [NCH-1:0] cancel_v;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        trans_delay_chan #(
            .DW      (DW),
            .THREE_D (THREE_D)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .d           (bus.d[g]),
            .ctl         (bus.ctl[g]),
            .rise_dly    (bus.rise_dly),
            .fall_dly    (bus.fall_dly),
            .turnoff_dly (bus.turnoff_dly),
            .q           (q_v[g]),
            .q_en        (q_en_v[g]),
            .busy        (busy_v[g]),
            .cancel      (cancel_v[g])
        );
    end

    assign bus.q      = q_v;
    assign bus.q_en   = q_en_v;
    assign bus.busy   = busy_v;
    assign bus.cancel = cancel_v;

endmodule

// File: tb/tb_trans_delay_bank.sv
// Bench for trans_delay_bank: two-delay and three-delay instances on shared stimulus.
module tb_trans_delay_bank;

    localparam int NCH = 4;
    localparam int DW  = 6;

    logic clk;
    logic reset;

    trans_delay_bank_if #(.NCH(NCH), .DW(DW)) bus0 ();
    trans_delay_bank_if #(.NCH(NCH), .DW(DW)) bus1 ();

    trans_delay_bank #(.NCH(NCH), .DW(DW), .THREE_D(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    trans_delay_bank #(.NCH(NCH), .DW(DW), .THREE_D(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [3:0] d_r, ctl_r;
    int rise_r, fall_r, toff_r;

    // Reference: each output holds a value plus at most one scheduled (value, due-cycle) event.
    longint cyc = 0;
    int     m_out [2][NCH];
    bit     m_pv  [2][NCH];
    int     m_pval[2][NCH];
    longint m_due [2][NCH];
    bit     m_cnc [2][NCH];

    typedef struct {
        logic       rst;
        logic [3:0] d;
        logic [3:0] ctl;
        int         rise, fall, toff;
        logic       eq, een, ebusy, ecan;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] d, input logic [3:0] ctl,
                         input int rise, input int fall, input int toff);
        reset = rst; d_r = d; ctl_r = ctl; rise_r = rise; fall_r = fall; toff_r = toff;
        bus0.d = d; bus0.ctl = ctl;
        bus0.rise_dly = DW'(rise); bus0.fall_dly = DW'(fall); bus0.turnoff_dly = DW'(toff);
        bus1.d = d; bus1.ctl = ctl;
        bus1.rise_dly = DW'(rise); bus1.fall_dly = DW'(fall); bus1.turnoff_dly = DW'(toff);
    endtask

    function automatic int delay_for(input int tgt, input int k);
        if (tgt == 1) return rise_r;
        if (tgt == 0) return fall_r;
        if (k == 1) return toff_r;
        return (rise_r < fall_r) ? rise_r : fall_r;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NCH; c++) begin
                int t;
                int dl;
                m_cnc[k][c] = 0;
                if (reset) begin
                    m_out[k][c] = 2; m_pv[k][c] = 0;
                    continue;
                end
                t = ctl_r[c] ? 2 : int'(d_r[c]);
                if (m_pv[k][c] && t == m_pval[k][c]) begin
                    if (cyc == m_due[k][c]) begin
                        m_out[k][c] = t; m_pv[k][c] = 0;
                    end
                end else if (m_pv[k][c] && t == m_out[k][c]) begin
                    m_pv[k][c] = 0; m_cnc[k][c] = 1;
                end else if (t != m_out[k][c]) begin
                    dl = delay_for(t, k);
                    if (dl == 0) begin
                        m_out[k][c] = t; m_pv[k][c] = 0;
                    end else begin
                        m_pv[k][c] = 1; m_pval[k][c] = t; m_due[k][c] = cyc + dl;
                    end
                end
            end
        end
    endtask

    task automatic compare_model();
        for (int k = 0; k < 2; k++) begin
            logic [3:0] eq, een, eb, ec;
            for (int c = 0; c < NCH; c++) begin
                eq[c]  = (m_out[k][c] == 1);
                een[c] = (m_out[k][c] != 2);
                eb[c]  = m_pv[k][c];
                ec[c]  = m_cnc[k][c];
            end
            check($sformatf("mdl%0d_q@%0d", k, cyc),      k ? bus1.q      : bus0.q,      eq);
            check($sformatf("mdl%0d_q_en@%0d", k, cyc),   k ? bus1.q_en   : bus0.q_en,   een);
            check($sformatf("mdl%0d_busy@%0d", k, cyc),   k ? bus1.busy   : bus0.busy,   eb);
            check($sformatf("mdl%0d_cancel@%0d", k, cyc), k ? bus1.cancel : bus0.cancel, ec);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        compare_model();
    endtask

    task automatic addn(input int n, input logic rst, input logic [3:0] d, input logic [3:0] ctl,
                        input int rise, input int fall, input int toff,
                        input logic eq, input logic een, input logic eb, input logic ec);
        vec_t v;
        v.rst = rst; v.d = d; v.ctl = ctl; v.rise = rise; v.fall = fall; v.toff = toff;
        v.eq = eq; v.een = een; v.ebusy = eb; v.ecan = ec;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        drive(1'b1, 4'h0, 4'hF, 3, 4, 6);

        // Expected ch0 of the two-delay instance after each edge.
        addn(2, 1, 4'h0, 4'hF, 3, 4, 6, 0, 0, 0, 0);
        addn(4, 0, 4'h0, 4'hE, 3, 4, 6, 0, 0, 1, 0);  // Z->0 fall=4
        addn(2, 0, 4'h0, 4'hE, 3, 4, 6, 0, 1, 0, 0);
        addn(3, 0, 4'h1, 4'hE, 3, 4, 6, 0, 1, 1, 0);  // 0->1 rise=3
        addn(2, 0, 4'h1, 4'hE, 3, 4, 6, 1, 1, 0, 0);
        addn(4, 0, 4'h0, 4'hE, 3, 4, 6, 1, 1, 1, 0);  // 1->0 fall=4
        addn(2, 0, 4'h0, 4'hE, 3, 4, 6, 0, 1, 0, 0);
        addn(2, 0, 4'h0, 4'hF, 3, 2, 6, 0, 1, 1, 0);  // to Z, min(3,2)
        addn(1, 0, 4'h0, 4'hF, 3, 2, 6, 0, 0, 0, 0);
        addn(3, 0, 4'h1, 4'hE, 3, 2, 6, 0, 0, 1, 0);  // Z->1 rise=3
        addn(2, 0, 4'h1, 4'hE, 3, 2, 6, 1, 1, 0, 0);
        addn(4, 0, 4'h0, 4'hE, 5, 4, 6, 1, 1, 1, 0);
        addn(1, 0, 4'h0, 4'hE, 5, 4, 6, 0, 1, 0, 0);
        addn(2, 0, 4'h1, 4'hE, 5, 4, 6, 0, 1, 1, 0);  // glitch shorter than rise=5
        addn(1, 0, 4'h0, 4'hE, 5, 4, 6, 0, 1, 0, 1);
        addn(2, 0, 4'h0, 4'hE, 5, 4, 6, 0, 1, 0, 0);

        #2;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].d, vecs[i].ctl, vecs[i].rise, vecs[i].fall, vecs[i].toff);
            step();
            check($sformatf("tbl%0d_q0", i),      bus0.q[0],      vecs[i].eq);
            check($sformatf("tbl%0d_q_en0", i),   bus0.q_en[0],   vecs[i].een);
            check($sformatf("tbl%0d_busy0", i),   bus0.busy[0],   vecs[i].ebusy);
            check($sformatf("tbl%0d_cancel0", i), bus0.cancel[0], vecs[i].ecan);
        end

        // Three-delay instance: pending rise rescheduled to turn-off.
        drive(1'b0, 4'h0, 4'hE, 5, 4, 6);
        for (int i = 0; i < 10; i++) step();
        check("resch_pre_en", bus1.q_en[0], 1);
        check("resch_pre_busy", bus1.busy[0], 0);
        drive(1'b0, 4'h1, 4'hE, 5, 4, 6);
        step();
        check("resch_t0_busy", bus1.busy[0], 1);
        drive(1'b0, 4'h1, 4'hF, 5, 4, 6);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("resch_wait%0d_en", i), bus1.q_en[0], 1);
            check($sformatf("resch_wait%0d_q", i), bus1.q[0], 0);
            check($sformatf("resch_wait%0d_cancel", i), bus1.cancel[0], 0);
        end
        step();
        check("resch_done_en", bus1.q_en[0], 0);
        check("resch_done_busy", bus1.busy[0], 0);
        check("resch_done_cancel", bus1.cancel[0], 0);

        // Delay latched at schedule time, zero delay, reset mid-pending.
        drive(1'b0, 4'h1, 4'hE, 3, 4, 6);
        for (int i = 0; i < 10; i++) step();
        check("latch_pre_q", bus0.q[0], 1);
        drive(1'b0, 4'h0, 4'hE, 3, 4, 6);
        step();
        check("latch_t0_busy", bus0.busy[0], 1);
        drive(1'b0, 4'h0, 4'hE, 3, 1, 6);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("latch_wait%0d_q", i), bus0.q[0], 1);
            check($sformatf("latch_wait%0d_busy", i), bus0.busy[0], 1);
        end
        step();
        check("latch_done_q", bus0.q[0], 0);
        check("latch_done_busy", bus0.busy[0], 0);
        drive(1'b0, 4'h1, 4'hE, 0, 4, 6);
        step();
        check("zero_dly_q", bus0.q[0], 1);
        check("zero_dly_busy", bus0.busy[0], 0);
        drive(1'b0, 4'h0, 4'hE, 0, 4, 6);
        step();
        step();
        check("rst_pre_busy", bus0.busy[0], 1);
        drive(1'b1, 4'h0, 4'hE, 0, 4, 6);
        step();
        check("rst_q_en0", bus0.q_en, 0);
        check("rst_busy0", bus0.busy, 0);
        check("rst_cancel0", bus0.cancel, 0);
        check("rst_q_en1", bus1.q_en, 0);
        check("rst_busy1", bus1.busy, 0);
        drive(1'b0, 4'h0, 4'hE, 0, 4, 6);
        step();
        check("rst_post_cancel0", bus0.cancel, 0);

        // Random stimulus against the reference model.
        for (int i = 0; i < 500; i++) begin
            logic       r;
            logic [3:0] d, c;
            int ri, fa, to;
            r = ($urandom_range(0, 149) == 0);
            d = d_r; c = ctl_r; ri = rise_r; fa = fall_r; to = toff_r;
            if ($urandom_range(0, 2) == 0) d = 4'($urandom);
            if ($urandom_range(0, 4) == 0) c = 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                ri = $urandom_range(0, 7);
                fa = $urandom_range(0, 7);
                to = $urandom_range(0, 7);
            end
            drive(r, d, c, ri, fa, to);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
